// File: rtl/y_reduce_vec4.sv
// y_reduce_vec4: per-row dot-product reduction of 4-lane Q8.8 state/coefficient tiles.
// Two stages: P1 registers the lane products, P2 accumulates them and closes the row on the
// last tile with a saturated Q8.8 result held behind a valid/ready handshake.
// Optional build macro Y_REDUCE_ROUND_EN selects round-half-up instead of truncation.
// Reset rst_n is asynchronous and active-high.
module y_reduce_vec4 #(
    parameter int TILE_SIZE     = 4,
    parameter int W             = 16,
    parameter int ACC_W         = 40,
    parameter int TILES_PER_ROW = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [TILE_SIZE-1:0][W-1:0]    s_vec,
    input  logic [TILE_SIZE-1:0][W-1:0]    c_vec,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [W-1:0]                   y,
    output logic                           sat_flag,
    output logic                           len_err
);

    localparam int PW    = 2 * W;
    localparam int CNT_W = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TILES_PER_ROW - 1);

    // Q8.8 clamp limits expressed at accumulator width
    localparam logic signed [ACC_W-1:0] Y_MAX = $signed({{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Y_MIN = $signed({{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}});

    logic [TILE_SIZE-1:0][PW-1:0] prod;
    logic [TILE_SIZE-1:0][PW-1:0] p1_prod;
    logic                         p1_valid;
    logic                         p1_last;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      acc_next;
    logic signed [ACC_W-1:0]      pre_shift;
    logic signed [ACC_W-1:0]      shifted;
    logic [W-1:0]                 y_sat;
    logic                         sat_hit;
    logic [CNT_W-1:0]             cnt_q;
    logic                         accept;
    logic                         row_done;

    assign row_done = p1_valid && p1_last;
    // A closing row in flight or a pending result blocks new tiles: one result outstanding.
    assign in_ready = !out_valid && !row_done;
    assign accept   = in_valid && in_ready;

    // Lane products, Q16.16
    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            prod[i] = PW'($signed(s_vec[i]) * $signed(c_vec[i]));
        end
    end

    // Sum of registered products, accumulation and saturating Q8.8 conversion
    always_comb begin
        sum = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            sum = sum + $signed({{(ACC_W-PW){p1_prod[i][PW-1]}}, p1_prod[i]});
        end
        acc_next = acc_q + sum;
`ifdef Y_REDUCE_ROUND_EN
        pre_shift = acc_next + ACC_W'(128);
`else
        pre_shift = acc_next;
`endif
        shifted = pre_shift >>> 8;
        sat_hit = 1'b0;
        if (shifted > Y_MAX) begin
            y_sat   = {1'b0, {(W-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (shifted < Y_MIN) begin
            y_sat   = {1'b1, {(W-1){1'b0}}};
            sat_hit = 1'b1;
        end else begin
            y_sat = shifted[W-1:0];
        end
    end

    // Stage P1: capture products and row framing of each accepted tile
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            p1_prod  <= '0;
            p1_valid <= 1'b0;
            p1_last  <= 1'b0;
        end else begin
            p1_valid <= accept;
            if (accept) begin
                p1_prod <= prod;
                p1_last <= in_last;
            end
        end
    end

    // Stage P2: accumulate, close the row into y, and run the output handshake
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (p1_valid) begin
                acc_q <= p1_last ? '0 : acc_next;
            end
            if (row_done) begin
                out_valid <= 1'b1;
                y         <= y_sat;
                if (sat_hit) begin
                    sat_flag <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Tile counter for row-length checking; the row always closes on in_last
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q   <= '0;
            len_err <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                cnt_q <= '0;
                if (cnt_q != CNT_MAX) begin
                    len_err <= 1'b1;
                end
            end else if (cnt_q == CNT_MAX) begin
                len_err <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_reduce_vec4.sv
// Testbench for y_reduce_vec4: directed rows checked against a row-level arithmetic model,
// plus literal expectations for each directed case.
module tb_y_reduce_vec4;

    localparam int TPR = 4;

    typedef logic [3:0][15:0] vec_t;
    typedef struct {
        int y;
        bit sat;
        bit len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    vec_t        s_vec = '0;
    vec_t        c_vec = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] y;
    logic        sat_flag;
    logic        len_err;

    int total = 0;
    int bad = 0;

    y_reduce_vec4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_vec     (s_vec),
        .c_vec     (c_vec),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat_flag  (sat_flag),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Row model: exact integer dot products, floor (or round-half-up) divide by 256, clamp
    longint row_sum = 0;
    int     row_tiles = 0;
    bit     m_sat = 0;
    bit     m_len = 0;
    exp_t   exp_q[$];
    int     n_out = 0;
    int     last_y = 0;
    int     last_acc_cyc = 0;
    bit     prev_ov = 0;

    function automatic longint floor_div256(input longint v);
        longint r;
        r = ((v % 256) + 256) % 256;
        return (v - r) / 256;
    endfunction

    // Monitor/compare: model update on accepts, check every delivered result
    always @(negedge clk) begin
        exp_t e;
        longint q;
        longint t;
        if (rst_n) begin
            row_sum = 0;
            row_tiles = 0;
            m_sat = 0;
            m_len = 0;
            exp_q.delete();
            prev_ov = 0;
        end else begin
            if (out_valid) begin
                check("out_blocks_in_ready", in_ready, 0);
                if (!prev_ov) check("latency", cyc - last_acc_cyc, 2);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("model_y", $signed(y), e.y);
                        check("model_sat_flag", sat_flag, e.sat);
                        check("model_len_err", len_err, e.len);
                    end
                    last_y = $signed(y);
                    n_out++;
                end
            end
            prev_ov = out_valid;
            if (in_valid && in_ready) begin
                t = 0;
                for (int i = 0; i < 4; i++) begin
                    t += longint'($signed(s_vec[i])) * longint'($signed(c_vec[i]));
                end
                row_sum += t;
                row_tiles++;
                if (in_last) begin
`ifdef Y_REDUCE_ROUND_EN
                    q = floor_div256(row_sum + 128);
`else
                    q = floor_div256(row_sum);
`endif
                    if (q > 32767) begin
                        q = 32767;
                        m_sat = 1;
                    end else if (q < -32768) begin
                        q = -32768;
                        m_sat = 1;
                    end
                    if (row_tiles != TPR) m_len = 1;
                    e.y = int'(q);
                    e.sat = m_sat;
                    e.len = m_len;
                    exp_q.push_back(e);
                    row_sum = 0;
                    row_tiles = 0;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    function automatic vec_t splat(input logic [15:0] v);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = v;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge
    task automatic send_tile(input vec_t s, input vec_t c, input bit last);
        int guard;
        in_valid = 1'b1;
        s_vec = s;
        c_vec = c;
        in_last = last;
        guard = 0;
        @(negedge clk);
        while (!in_ready) begin
            guard++;
            if (guard > 50) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_row(input vec_t s, input vec_t c, input int n);
        for (int i = 0; i < n; i++) send_tile(s, c, i == n - 1);
    endtask

    task automatic wait_out();
        int start;
        int guard;
        start = n_out;
        guard = 0;
        while (n_out == start && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (n_out == start) check("result_timeout", 0, 1);
        #1;
    endtask

    initial begin
        vec_t s;
        vec_t c;
        int guard;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_len_err", len_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // basic row
        send_row(splat(16'd256), splat(16'd256), 4);
        wait_out();
        check("basic_y", last_y, 4096);
        check("basic_sat", sat_flag, 0);
        check("basic_len", len_err, 0);

        // sign handling
        send_row(splat(-16'sd256), splat(16'd256), 4);
        wait_out();
        check("neg_y", last_y, -4096);
        send_row(splat(-16'sd256), splat(-16'sd256), 4);
        wait_out();
        check("negneg_y", last_y, 4096);

        // saturation, sticky flag
        send_row(splat(16'sd32767), splat(16'sd32767), 4);
        wait_out();
        check("sat_y", last_y, 32767);
        check("sat_flag_set", sat_flag, 1);
        send_row(splat(16'd256), splat(16'd256), 4);
        wait_out();
        check("after_sat_y", last_y, 4096);
        check("sat_flag_sticky", sat_flag, 1);

        // rounding boundaries
        s = '0;
        c = '0;
        s[0] = 16'sd1;
        c[0] = 16'sd128;
        send_tile(s, c, 1'b0);
        send_row('0, '0, 3);
        wait_out();
`ifdef Y_REDUCE_ROUND_EN
        check("round_pos_y", last_y, 1);
`else
        check("round_pos_y", last_y, 0);
`endif
        s[0] = -16'sd1;
        send_tile(s, c, 1'b0);
        send_row('0, '0, 3);
        wait_out();
`ifdef Y_REDUCE_ROUND_EN
        check("round_neg_y", last_y, 0);
`else
        check("round_neg_y", last_y, -1);
`endif

        // backpressure
        out_ready = 1'b0;
        send_row(splat(16'd256), splat(16'd256), 4);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_y", y, 4096);
            check("bp_hold_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_out();
        check("bp_y", last_y, 4096);
        @(negedge clk);
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        @(posedge clk);
        #1;

        // short row
        send_row(splat(16'd256), splat(16'd256), 2);
        wait_out();
        check("short_y", last_y, 2048);
        check("short_len_err", len_err, 1);

        // reset mid-row discards partial accumulation
        send_tile(splat(16'd256), splat(16'd256), 1'b0);
        send_tile(splat(16'd256), splat(16'd256), 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_len_err", len_err, 0);
        check("midrst_sat_flag", sat_flag, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        send_row(splat(16'd256), splat(16'd256), 4);
        wait_out();
        check("post_rst_y", last_y, 4096);
        check("post_rst_len", len_err, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
